alu_seq_core: RTL and testbench

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

---
 rtl/alu_seq_core.sv | 126 ++++++++++++
 tb/tb_alu_seq_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// Two-stage fetch/execute ALU sequencer: instructions are fetched from a
// loadable program memory and executed one per cycle, with sticky HALT.
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int WRAP  = 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int IW   = 3 + 2 * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [IW-1:0]    prog_data,
  output logic [IW-1:0]    instruccion,
  output logic [2:0]       outOp,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic [WIDTH-1:0] resultado,
  output logic             res_valid,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic [AW-1:0]    pc,
  output logic             halted
);

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_CMP, OP_HALT
  } op_t;

  logic [IW-1:0]    mem [DEPTH];
  logic             ins_valid;
  logic             fetch_done;
  op_t              op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] flag_src;
  logic             alu_c;
  logic             run;
  logic             halt_now;
  logic             last_fetch;

  assign outOp = instruccion[IW-1 -: 3];
  assign outA  = instruccion[2*WIDTH-1 -: WIDTH];
  assign outB  = instruccion[WIDTH-1:0];
  assign op    = op_t'(outOp);

  // NOTE: program memory has no reset branch; its contents must survive reset
  // and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (prog_we && (!m || halted || reset)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    sum      = {1'b0, outA} + {1'b0, outB};
    diff     = {1'b0, outA} - {1'b0, outB};
    alu_res  = resultado;
    alu_c    = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_AND: alu_res = outA & outB;
      OP_OR:  alu_res = outA | outB;
      OP_XOR: alu_res = outA ^ outB;
      OP_SHL: begin alu_res = {outA[WIDTH-2:0], 1'b0}; alu_c = outA[WIDTH-1]; end
      OP_CMP: alu_c = diff[WIDTH];
      default: ;
    endcase
    // CMP sets flags from the difference but leaves resultado untouched
    flag_src = (op == OP_CMP) ? diff[WIDTH-1:0] : alu_res;
  end

  assign run        = m && !halted;
  assign halt_now   = ins_valid && (op == OP_HALT);
  assign last_fetch = (WRAP == 0) && (pc == AW'(DEPTH - 1));

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, which is what makes the two stages overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instruccion <= '0;
      ins_valid   <= 1'b0;
      fetch_done  <= 1'b0;
      resultado   <= '0;
      res_valid   <= 1'b0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_n      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (run) begin
        if (halt_now) begin
          halted <= 1'b1;
        end else begin
          if (ins_valid) begin
            resultado <= alu_res;
            flag_z    <= (flag_src == '0);
            flag_n    <= flag_src[WIDTH-1];
            flag_c    <= alu_c;
            res_valid <= 1'b1;
            // without wrap, the final word's result ends the program
            if (fetch_done) halted <= 1'b1;
          end
          if (!fetch_done) begin
            instruccion <= mem[pc];
            ins_valid   <= 1'b1;
            if (last_fetch) fetch_done <= 1'b1;
            else            pc <= pc + 1'b1;
          end else begin
            ins_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized and directed bench for alu_seq_core against a spec-level model.
module tb_alu_seq_core;
  localparam int W  = 8;
  localparam int D  = 32;
  localparam int IW = 3 + 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, m, prog_we;
  logic [4:0]    prog_addr;
  logic [IW-1:0] prog_data;
  logic [IW-1:0] instruccion;
  logic [2:0]    outOp;
  logic [W-1:0]  outA, outB, resultado;
  logic          res_valid, flag_z, flag_c, flag_n, halted;
  logic [4:0]    pc;

  logic          s_reset, s_m, s_we;
  logic [1:0]    s_addr;
  logic [IW-1:0] s_data;
  logic [IW-1:0] w_ins, t_ins;
  logic [2:0]    w_op, t_op;
  logic [W-1:0]  w_a, w_b, w_res, t_a, t_b, t_res;
  logic          w_rv, w_z, w_c, w_n, w_halted, t_rv, t_z, t_c, t_n, t_halted;
  logic [1:0]    w_pc, t_pc;

  alu_seq_core #(.WIDTH(W), .DEPTH(D), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .m(m), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .instruccion(instruccion), .outOp(outOp), .outA(outA),
    .outB(outB), .resultado(resultado), .res_valid(res_valid), .flag_z(flag_z),
    .flag_c(flag_c), .flag_n(flag_n), .pc(pc), .halted(halted));

  alu_seq_core #(.WIDTH(W), .DEPTH(4), .WRAP(1)) dut_wrap (
    .clk(clk), .reset(s_reset), .m(s_m), .prog_we(s_we), .prog_addr(s_addr),
    .prog_data(s_data), .instruccion(w_ins), .outOp(w_op), .outA(w_a),
    .outB(w_b), .resultado(w_res), .res_valid(w_rv), .flag_z(w_z),
    .flag_c(w_c), .flag_n(w_n), .pc(w_pc), .halted(w_halted));

  alu_seq_core #(.WIDTH(W), .DEPTH(4), .WRAP(0)) dut_stop (
    .clk(clk), .reset(s_reset), .m(s_m), .prog_we(s_we), .prog_addr(s_addr),
    .prog_data(s_data), .instruccion(t_ins), .outOp(t_op), .outA(t_a),
    .outB(t_b), .resultado(t_res), .res_valid(t_rv), .flag_z(t_z),
    .flag_c(t_c), .flag_n(t_n), .pc(t_pc), .halted(t_halted));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: program image plus architectural state, one step per edge.
  logic [IW-1:0] mm [D];
  int            m_pc, m_res;
  logic [IW-1:0] m_ir;
  bit            m_iv, m_rv, m_z, m_c, m_n, m_halt;

  function automatic logic [IW-1:0] word(input int op, input int a, input int b);
    return {3'(op), 8'(a), 8'(b)};
  endfunction

  task automatic model_step();
    int op, a, b, val;
    if (prog_we && (!m || m_halt || reset)) mm[prog_addr] = prog_data;
    if (reset) begin
      m_pc = 0; m_ir = '0; m_iv = 0; m_res = 0; m_rv = 0;
      m_z = 0; m_c = 0; m_n = 0; m_halt = 0;
    end else if (!m || m_halt) begin
      m_rv = 0;
    end else begin
      op = int'(m_ir[18:16]); a = int'(m_ir[15:8]); b = int'(m_ir[7:0]);
      if (m_iv && op == 7) begin
        m_halt = 1; m_rv = 0;
      end else begin
        if (m_iv) begin
          m_c = 0;
          case (op)
            0: begin val = a + b; m_c = (val > 255); end
            1: begin val = a - b; m_c = (a < b); end
            2: val = a & b;
            3: val = a | b;
            4: val = a ^ b;
            5: begin val = a * 2; m_c = (a >= 128); end
            default: begin val = a - b; m_c = (a < b); end
          endcase
          val = ((val % 256) + 256) % 256;
          if (op != 6) m_res = val;
          m_z = (val == 0); m_n = (val >= 128); m_rv = 1;
        end else begin
          m_rv = 0;
        end
        m_ir = mm[m_pc]; m_pc = (m_pc + 1) % D; m_iv = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("instruccion", instruccion, m_ir);
    check("fields", {outOp, outA, outB}, m_ir);
    check("resultado", resultado, m_res);
    check("res_valid", res_valid, m_rv);
    check("flags", {flag_z, flag_c, flag_n}, {m_z, m_c, m_n});
    check("halted", halted, m_halt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic prog(input int addr, input logic [IW-1:0] data);
    prog_addr = 5'(addr); prog_data = data; prog_we = 1'b1;
    tick();
    prog_we = 1'b0;
  endtask

  function automatic logic [IW-1:0] rand_word();
    int op;
    op = ($urandom_range(0, 39) == 0) ? 7 : int'($urandom_range(0, 6));
    return word(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endfunction

  logic [4:0]   saved_pc;
  logic [W-1:0] saved_res;
  logic [1:0]   saved_spc;

  initial begin
    reset = 1'b1; m = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    s_reset = 1'b1; s_m = 1'b0; s_we = 1'b0; s_addr = '0; s_data = '0;
    tick();
    check("reset_pc", pc, 0);
    reset = 1'b0;

    for (int i = 0; i < D; i++) prog(i, rand_word());
    prog(0, word(0, 200, 100));
    prog(1, word(1, 5, 7));
    prog(2, word(6, 9, 9));
    prog(3, word(7, 0, 0));
    reset = 1'b1; tick(); reset = 1'b0;

    m = 1'b1;
    tick();
    check("fetch0", instruccion, word(0, 200, 100));
    tick();
    check("add_res", resultado, 44);
    check("add_c_z_v", {flag_c, flag_z, res_valid}, 3'b101);
    tick();
    check("sub_res", resultado, 254);
    check("sub_c_n", {flag_c, flag_n}, 2'b11);
    tick();
    check("cmp_res", resultado, 254);
    check("cmp_z_c", {flag_z, flag_c}, 2'b10);
    tick();
    check("halt_state", {halted, res_valid}, 2'b10);
    check("halt_pc", pc, 4);

    prog(4, word(0, 1, 2));
    for (int i = 0; i < 4; i++) begin
      m = i[0];
      tick();
      check("halt_sticky", halted, 1);
      check("halt_pc_hold", pc, 4);
      check("halt_ins_hold", instruccion, word(7, 0, 0));
    end

    m = 1'b1; reset = 1'b1;
    tick();
    check("rst_all", {pc, instruccion, resultado, res_valid, flag_z, flag_c, flag_n, halted}, '0);
    reset = 1'b0; m = 1'b0;
    prog(3, word(0, 10, 20));
    for (int i = 5; i < 12; i++) prog(i, word(0, i, 1));

    m = 1'b1;
    tick();
    check("refetch0", instruccion, word(0, 200, 100));
    for (int i = 0; i < 5; i++) tick();
    saved_pc = pc; saved_res = resultado;
    m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_pc", pc, saved_pc);
      check("freeze_res", resultado, saved_res);
      check("freeze_valid", res_valid, 0);
    end
    m = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      m         = ($urandom_range(0, 4) != 0);
      prog_we   = $urandom_range(0, 1) == 1;
      prog_addr = 5'($urandom_range(0, D - 1));
      prog_data = rand_word();
      tick();
    end
    reset = 1'b0; m = 1'b0; prog_we = 1'b0;

    s_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_addr = 2'(k); s_data = word(0, k + 1, k + 1); s_we = 1'b1;
      tick();
    end
    s_we = 1'b0; s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    check("small_pc0", {w_pc, t_pc}, 4'b0000);
    s_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wrap_pc", w_pc, (i + 1) % 4);
      if (i == 3) check("stop_not_yet", t_halted, 0);
    end
    check("stop_halted", t_halted, 1);
    check("stop_last_res", {t_res, t_rv}, {8'd8, 1'b1});
    check("wrap_running", w_halted, 0);
    saved_spc = t_pc;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stop_pc_hold", t_pc, saved_spc);
      check("stop_sticky", {t_halted, t_rv}, 2'b10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
